// File: rtl/ir_instr_queue.sv
// Issue-stage instruction FIFO: NUM_SCALAR_INSTR-wide in-order enqueue/pop, one-cycle enqueue-to-visible latency.
// Optional macro INSTRUCTION_QUEUE_BYPASS_EN forwards live inputs into free output lanes (zero-cycle path).
package drac_pkg;
    localparam int NUM_SCALAR_INSTR              = 2;
    localparam int INSTRUCTION_QUEUE_NUM_ENTRIES = 16;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] bits;
    } instr_t;

    typedef struct packed {
        instr_t     instr;
        logic [5:0] prd;
    } id_ir_stage_t;
endpackage

module ir_instr_queue
    import drac_pkg::*;
(
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  id_ir_stage_t                instruction_S_i [NUM_SCALAR_INSTR],
    input  logic                        flush_i,
    input  logic [NUM_SCALAR_INSTR-1:0] read_head_S_i,
    output id_ir_stage_t                instruction_S_o [NUM_SCALAR_INSTR],
    output logic                        full_o,
    output logic                        empty_o
);
    localparam int NL = NUM_SCALAR_INSTR;
    localparam int N  = INSTRUCTION_QUEUE_NUM_ENTRIES;
    localparam int PW = $clog2(N);
    localparam int CW = PW + 1;

    id_ir_stage_t  mem [N];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] num;

    id_ir_stage_t  live_dat [NL];
    logic [NL-1:0] wr_en;
    logic [PW-1:0] wr_idx [NL];
    int            numi;
    int            live_cnt;
    int            byp_cnt;
    int            avail;
    int            pop_cnt;
    int            spop_cnt;
    int            consumed;
    int            wr_cnt;
    logic          pop_go;

    always_comb begin
        numi     = int'(num);
        live_cnt = 0;
        for (int j = 0; j < NL; j++) live_dat[j] = '0;
        // Compact live lanes so the stored sequence has no holes.
        for (int k = 0; k < NL; k++) begin
            if (instruction_S_i[k].instr.valid) begin
                for (int j = 0; j < NL; j++)
                    if (j == live_cnt) live_dat[j] = instruction_S_i[k];
                live_cnt = live_cnt + 1;
            end
        end

        full_o  = (N - numi) < NL;
        empty_o = (numi == 0);

`ifdef INSTRUCTION_QUEUE_BYPASS_EN
        byp_cnt = full_o ? 0 : live_cnt;
`else
        byp_cnt = 0;
`endif
        avail = numi + byp_cnt;

        for (int k = 0; k < NL; k++) begin
            instruction_S_o[k] = '0;
            if (k < numi) begin
                instruction_S_o[k] = mem[PW'(int'(head) + k)];
            end else if (k < avail) begin
                for (int j = 0; j < NL; j++)
                    if (j == k - numi) instruction_S_o[k] = live_dat[j];
            end
        end

        // A lane pops only if every older lane also pops.
        pop_cnt = 0;
        pop_go  = 1'b1;
        for (int k = 0; k < NL; k++) begin
            pop_go = pop_go && read_head_S_i[k] && (k < avail);
            if (pop_go) pop_cnt = pop_cnt + 1;
        end
        spop_cnt = (pop_cnt < numi) ? pop_cnt : numi;
        consumed = pop_cnt - spop_cnt;
        wr_cnt   = full_o ? 0 : live_cnt - consumed;

        for (int j = 0; j < NL; j++) begin
            wr_en[j]  = !full_o && (j >= consumed) && (j < live_cnt);
            wr_idx[j] = PW'(int'(tail) + j - consumed);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            head <= '0;
            tail <= '0;
            num  <= '0;
        end else begin
            for (int j = 0; j < NL; j++)
                if (wr_en[j]) mem[wr_idx[j]] <= live_dat[j];
            head <= head + PW'(spop_cnt);
            tail <= tail + PW'(wr_cnt);
            num  <= CW'(numi + wr_cnt + consumed - pop_cnt);
        end
    end
endmodule

// File: tb/tb_ir_instr_queue.sv
// Directed bench for ir_instr_queue: stimulus pushes expected pops into a scoreboard, a negedge monitor checks them.
module tb_ir_instr_queue;
    import drac_pkg::*;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         flush_i;
    id_ir_stage_t in_lanes [NUM_SCALAR_INSTR];
    id_ir_stage_t out_lanes [NUM_SCALAR_INSTR];
    logic [1:0]   read_head;
    logic         full;
    logic         empty;

    id_ir_stage_t exp_q [$];
    id_ir_stage_t zero_e;
    id_ir_stage_t exp_e;
    int           vectors     = 0;
    int           miscompares = 0;
    logic         mon_go;

    always #5 clk = ~clk;

    ir_instr_queue dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .instruction_S_i (in_lanes),
        .flush_i         (flush_i),
        .read_head_S_i   (read_head),
        .instruction_S_o (out_lanes),
        .full_o          (full),
        .empty_o         (empty)
    );

    function automatic id_ir_stage_t mk(input int id);
        id_ir_stage_t e;
        e             = '0;
        e.instr.valid = 1'b1;
        e.instr.pc    = 32'(id);
        e.instr.bits  = 32'(id * 7 + 1);
        e.prd         = 6'(id);
        return e;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %b, required %b", name, act, req);
        end
    endtask

    task automatic chk_ent(input string name, input id_ir_stage_t act, input id_ir_stage_t req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got valid %b pc %0d, required valid %b pc %0d",
                     name, act.instr.valid, act.instr.pc, req.instr.valid, req.instr.pc);
        end
    endtask

    task automatic step(input logic v0, input int id0, input logic v1, input int id1,
                        input logic [1:0] rd, input logic fl);
        in_lanes[0] = v0 ? mk(id0) : zero_e;
        in_lanes[1] = v1 ? mk(id1) : zero_e;
        read_head   = rd;
        flush_i     = fl;
        @(posedge clk);
        #1;
        in_lanes[0] = zero_e;
        in_lanes[1] = zero_e;
        read_head   = 2'b00;
        flush_i     = 1'b0;
    endtask

    // Scoreboard monitor: every lane the DUT actually pops must match the next expected entry.
    always @(negedge clk) begin
        if (!rst_i && !flush_i) begin
            mon_go = 1'b1;
            for (int k = 0; k < NUM_SCALAR_INSTR; k++) begin
                mon_go = mon_go && read_head[k] && out_lanes[k].instr.valid;
                if (mon_go) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL pop_lane%0d: got pc %0d, required no entry", k, out_lanes[k].instr.pc);
                    end else begin
                        exp_e = exp_q.pop_front();
                        if (out_lanes[k] !== exp_e) begin
                            miscompares++;
                            $display("FAIL pop_lane%0d: got valid %b pc %0d, required valid %b pc %0d", k,
                                     out_lanes[k].instr.valid, out_lanes[k].instr.pc,
                                     exp_e.instr.valid, exp_e.instr.pc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        zero_e      = '0;
        rst_i       = 1'b1;
        flush_i     = 1'b0;
        in_lanes[0] = '0;
        in_lanes[1] = '0;
        read_head   = 2'b00;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_bit("rst_empty", empty, 1'b1);
        chk_bit("rst_full", full, 1'b0);
        chk_ent("rst_out0", out_lanes[0], zero_e);
        chk_ent("rst_out1", out_lanes[1], zero_e);

        // Fill: 8 double writes reach 16 entries, tail wraps to 0
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back(mk(2 * c + 1));
            exp_q.push_back(mk(2 * c + 2));
            step(1'b1, 2 * c + 1, 1'b1, 2 * c + 2, 2'b00, 1'b0);
            chk_bit($sformatf("fill_full_%0d", c), full, c == 7);
            chk_bit($sformatf("fill_empty_%0d", c), empty, 1'b0);
            if (c == 0) chk_ent("fill_latency", out_lanes[0], mk(1));
        end
        step(1'b1, 100, 1'b1, 101, 2'b00, 1'b0);
        chk_bit("full_ignore_full", full, 1'b1);
        chk_ent("full_ignore_head0", out_lanes[0], mk(1));
        chk_ent("full_ignore_head1", out_lanes[1], mk(2));

        // Drain two per cycle
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 0, 1'b0, 0, 2'b11, 1'b0);
            chk_bit($sformatf("drain_empty_%0d", c), empty, c == 7);
            chk_bit($sformatf("drain_full_%0d", c), full, 1'b0);
        end

        // Partial pop: one entry, both lanes requested
        exp_q.push_back(mk(20));
        step(1'b1, 20, 1'b0, 0, 2'b00, 1'b0);
        step(1'b0, 0, 1'b0, 0, 2'b11, 1'b0);
        chk_bit("partial_empty", empty, 1'b1);
        chk_ent("partial_out0", out_lanes[0], zero_e);

        // Out-of-order request {0,1} pops nothing
        exp_q.push_back(mk(30));
        exp_q.push_back(mk(31));
        exp_q.push_back(mk(32));
        exp_q.push_back(mk(33));
        step(1'b1, 30, 1'b1, 31, 2'b00, 1'b0);
        step(1'b1, 32, 1'b1, 33, 2'b00, 1'b0);
        step(1'b0, 0, 1'b0, 0, 2'b10, 1'b0);
        chk_ent("ooo_out0", out_lanes[0], mk(30));
        chk_ent("ooo_out1", out_lanes[1], mk(31));
        step(1'b0, 0, 1'b0, 0, 2'b11, 1'b0);
        step(1'b0, 0, 1'b0, 0, 2'b11, 1'b0);
        chk_bit("ooo_empty", empty, 1'b1);

        // Move head/tail to 15, then concurrent write+pop across the wrap
        for (int c = 0; c < 5; c++) begin
            exp_q.push_back(mk(40 + 2 * c));
            exp_q.push_back(mk(41 + 2 * c));
            step(1'b1, 40 + 2 * c, 1'b1, 41 + 2 * c, 2'b00, 1'b0);
        end
        for (int c = 0; c < 5; c++) step(1'b0, 0, 1'b0, 0, 2'b11, 1'b0);
        chk_bit("pre_wrap_empty", empty, 1'b1);
        exp_q.push_back(mk(60));
        exp_q.push_back(mk(61));
        step(1'b1, 60, 1'b1, 61, 2'b00, 1'b0);
        exp_q.push_back(mk(62));
        exp_q.push_back(mk(63));
        step(1'b1, 62, 1'b1, 63, 2'b11, 1'b0);
        chk_ent("wrap_out0", out_lanes[0], mk(62));
        chk_ent("wrap_out1", out_lanes[1], mk(63));
        chk_bit("wrap_empty", empty, 1'b0);
        step(1'b0, 0, 1'b0, 0, 2'b11, 1'b0);
        chk_bit("wrap_drained", empty, 1'b1);

        // Flush with 10 entries, plus same-cycle write and read
        for (int c = 0; c < 5; c++) step(1'b1, 70 + 2 * c, 1'b1, 71 + 2 * c, 2'b00, 1'b0);
        chk_bit("preflush_full", full, 1'b0);
        chk_bit("preflush_empty", empty, 1'b0);
        step(1'b1, 80, 1'b1, 81, 2'b11, 1'b1);
        chk_bit("flush_empty", empty, 1'b1);
        chk_bit("flush_full", full, 1'b0);
        chk_ent("flush_out0", out_lanes[0], zero_e);
        chk_ent("flush_out1", out_lanes[1], zero_e);
        exp_q.push_back(mk(90));
        step(1'b1, 90, 1'b0, 0, 2'b00, 1'b0);
        chk_ent("postflush_out0", out_lanes[0], mk(90));
        step(1'b0, 0, 1'b0, 0, 2'b01, 1'b0);
        chk_bit("postflush_empty", empty, 1'b1);

        chk_bit("scoreboard_drained", exp_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
